// File: rtl/axis_sample_packetizer_if.sv
// AXI-Stream output bundle of the sample packetizer.
//   tdata  : sample payload
//   tvalid : beat valid
//   tready : sink ready
//   tlast  : final beat of a packet
// The packetizer drives this through the master modport and the sink uses the slave modport.
interface axis_sample_packetizer_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_sample_packetizer.sv
// Packetizer that sits after the moving-average decimator.
// It takes valid-only samples, which never see backpressure. Each sample is arithmetically
// right-shifted by a per-packet amount and buffered in a first-word-fall-through FIFO.
// The FIFO output is sent as fixed-length AXI-Stream packets. If the FIFO is full, the
// incoming sample is dropped and a sticky flag is raised.
// Ports:
//   clk, rst               : clock and synchronous active-high reset
//   enable                 : start/stop request; takes effect only at packet boundaries
//   pkt_len, shift         : packet length (0 means 1) and shift amount; latched at packet start
//   in_data_valid, in_data : sample strobe and signed sample from the decimator
//   m_axis                 : AXI-Stream master (tdata, tvalid, tready, tlast)
//   overflow               : sticky drop flag
//   clear_overflow         : clears the flag; a drop in the same cycle keeps it set
//   fifo_level             : FIFO occupancy
//   pkt_count              : packets completed on the output; wraps
module axis_sample_packetizer #(
  parameter int DATA_WIDTH      = 32,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int PKT_LEN_WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [PKT_LEN_WIDTH-1:0]   pkt_len,
  input  logic [4:0]                 shift,
  input  logic                       in_data_valid,
  input  logic [DATA_WIDTH-1:0]      in_data,
  axis_sample_packetizer_if.master   m_axis,
  output logic                       overflow,
  input  logic                       clear_overflow,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_level,
  output logic [31:0]                pkt_count
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

  typedef enum logic {IDLE, STREAM} state_e;

  state_e                      state_q, state_d;
  logic [PKT_LEN_WIDTH-1:0]    wr_cnt_q, wr_cnt_d;
  logic [PKT_LEN_WIDTH-1:0]    len_q, len_d;
  logic [4:0]                  shift_q, shift_d;
  logic [FIFO_DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_LOG2:0]    level_q, level_d;
  logic                        tvalid_q, tvalid_d;
  logic                        overflow_q, overflow_d;
  logic [31:0]                 pkt_count_q, pkt_count_d;

  // Each entry holds {tlast, shifted sample}.
  logic [DATA_WIDTH:0]         mem [DEPTH];
  logic [DATA_WIDTH:0]         head;
  logic                        mem_we;
  logic [DATA_WIDTH:0]         mem_wdata;

  logic                        pop;
  logic                        push;
  logic                        drop;
  logic                        tlast_bit;
  logic [PKT_LEN_WIDTH-1:0]    len_eff;
  logic [4:0]                  shift_eff;
  logic signed [DATA_WIDTH-1:0] shifted;

  assign head = mem[rd_ptr_q];

  // NOTE: every always_comb output gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    len_d       = len_q;
    shift_d     = shift_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    pkt_count_d = pkt_count_q;
    push        = 1'b0;
    drop        = 1'b0;
    mem_we      = 1'b0;

    pop = tvalid_q & m_axis.tready;

    // The first write attempt of a packet uses the live settings. Those same values are latched for the rest of the packet.
    if (wr_cnt_q == '0) begin
      len_eff   = (pkt_len == '0) ? PKT_LEN_WIDTH'(1) : pkt_len;
      shift_eff = shift;
    end else begin
      len_eff   = len_q;
      shift_eff = shift_q;
    end

    tlast_bit = (wr_cnt_q == len_eff - PKT_LEN_WIDTH'(1));
    shifted   = $signed(in_data) >>> shift_eff;
    mem_wdata = {tlast_bit, shifted};

    unique case (state_q)
      IDLE: begin
        if (enable) state_d = STREAM;
      end
      STREAM: begin
        if (in_data_valid) begin
          len_d   = len_eff;
          shift_d = shift_eff;
          // The MSB of level is set only when the FIFO is full. A pop in the same cycle frees a slot.
          if (!level_q[FIFO_DEPTH_LOG2] || pop) begin
            push     = 1'b1;
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + FIFO_DEPTH_LOG2'(1);
            wr_cnt_d = tlast_bit ? '0 : wr_cnt_q + PKT_LEN_WIDTH'(1);
          end else begin
            drop = 1'b1;
          end
        end
        // Stop on the same edge that closes the packet, so a sample in the following cycle is not taken as the start of a new packet.
        if (!enable && (wr_cnt_d == '0)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      rd_ptr_d = rd_ptr_q + FIFO_DEPTH_LOG2'(1);
      if (head[DATA_WIDTH]) pkt_count_d = pkt_count_q + 32'd1;
    end

    if (push && !pop)      level_d = level_q + (FIFO_DEPTH_LOG2+1)'(1);
    else if (pop && !push) level_d = level_q - (FIFO_DEPTH_LOG2+1)'(1);

    if (clear_overflow) overflow_d = 1'b0;
    if (drop)           overflow_d = 1'b1;

    tvalid_d = (level_d != '0);
  end

  // NOTE: all sequential state uses non-blocking assignments, so every flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_cnt_q    <= '0;
      len_q       <= PKT_LEN_WIDTH'(1);
      shift_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      tvalid_q    <= 1'b0;
      overflow_q  <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      len_q       <= len_d;
      shift_q     <= shift_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      tvalid_q    <= tvalid_d;
      overflow_q  <= overflow_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  // NOTE: the storage array is not reset. The pointers and level define which entries are valid, and the output is masked while empty.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q] <= mem_wdata;
  end

  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tdata  = tvalid_q ? head[DATA_WIDTH-1:0] : '0;
  assign m_axis.tlast  = tvalid_q & head[DATA_WIDTH];
  assign overflow      = overflow_q;
  assign fifo_level    = level_q;
  assign pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_axis_sample_packetizer.sv
// Self-checking bench for axis_sample_packetizer. A queue-based reference model is advanced once per clock.
module tb_axis_sample_packetizer;

  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] pkt_len = '0;
  logic [4:0]  shift = '0;
  logic        in_data_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        clear_overflow = 1'b0;
  logic        overflow;
  logic [4:0]  fifo_level;
  logic [31:0] pkt_count;

  axis_sample_packetizer_if #(.DATA_WIDTH(DW)) m_axis ();

  axis_sample_packetizer dut (
    .clk(clk), .rst(rst), .enable(enable), .pkt_len(pkt_len), .shift(shift),
    .in_data_valid(in_data_valid), .in_data(in_data), .m_axis(m_axis),
    .overflow(overflow), .clear_overflow(clear_overflow),
    .fifo_level(fifo_level), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: stream on/off, write position in packet, latched settings, and the FIFO contents as a queue.
  bit          m_streaming;
  int          m_cnt;
  int          m_len;
  int          m_shift;
  logic [32:0] m_q[$];
  bit          m_ovf;
  logic [31:0] m_pkts;
  logic [32:0] exp_beats[$];
  logic [32:0] obs_beats[$];

  task automatic model_reset();
    m_streaming = 0; m_cnt = 0; m_len = 1; m_shift = 0;
    m_q.delete(); m_ovf = 0; m_pkts = '0;
    exp_beats.delete(); obs_beats.delete();
  endtask

  // Called just after a falling edge. It drives one cycle of inputs, records any handshake seen on the output,
  // advances the model across the rising edge, and returns on the next falling edge.
  task automatic drive_cycle(input bit en, input int len, input int sh, input bit vld,
                             input logic [31:0] din, input bit rdy, input bit clr);
    bit pop, drop, last;
    logic [32:0] head;
    logic signed [31:0] sd;
    enable = en; pkt_len = 16'(len); shift = 5'(sh); in_data_valid = vld;
    in_data = din; m_axis.tready = rdy; clear_overflow = clr;
    #1;
    if (m_axis.tvalid && rdy) obs_beats.push_back({m_axis.tlast, m_axis.tdata});
    pop  = (m_q.size() != 0) && rdy;
    head = pop ? m_q[0] : '0;
    drop = 0;
    if (m_streaming) begin
      if (vld) begin
        if (m_cnt == 0) begin m_len = (len == 0) ? 1 : len; m_shift = sh; end
        if (m_q.size() < DEPTH || pop) begin
          last = (m_cnt == m_len - 1);
          sd = din;
          m_q.push_back({last, 32'(sd >>> m_shift)});
          m_cnt = last ? 0 : m_cnt + 1;
        end else begin
          drop = 1;
        end
      end
      if (!en && m_cnt == 0) m_streaming = 0;
    end else if (en) begin
      m_streaming = 1;
    end
    if (pop) begin
      void'(m_q.pop_front());
      exp_beats.push_back(head);
      if (head[32]) m_pkts = m_pkts + 32'd1;
    end
    if (clr)  m_ovf = 0;
    if (drop) m_ovf = 1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1; enable = 0; in_data_valid = 0; m_axis.tready = 0; clear_overflow = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (m_axis.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %0b want 0", m_axis.tvalid); end
    checks++; if (m_axis.tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata got %h want 0", m_axis.tdata); end
    checks++; if (m_axis.tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %0b want 0", m_axis.tlast); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", overflow); end
    checks++; if (pkt_count !== 32'd0) begin errors++; $display("FAIL reset_pkt_count got %0d want 0", pkt_count); end
    // While idle, samples are ignored.
    drive_cycle(0, 4, 0, 1, 32'd99, 1, 0);
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL idle_ignore level got %0d want 0", fifo_level); end
  endtask

  task automatic test_basic_packet();
    logic [32:0] b;
    apply_reset();
    drive_cycle(1, 4, 0, 1, 32'd77, 1, 0);  // transition cycle: this sample is dropped without setting overflow
    for (int i = 1; i <= 8; i++) drive_cycle(1, 4, 0, 1, 32'(i), 1, 0);
    for (int i = 0; i < 4; i++) drive_cycle(1, 4, 0, 0, '0, 1, 0);
    checks++; if (obs_beats.size() != 8) begin errors++; $display("FAIL basic_beats got %0d want 8", obs_beats.size()); end
    for (int i = 0; i < obs_beats.size() && i < 8; i++) begin
      b = obs_beats[i];
      checks++;
      if (b !== {(i % 4) == 3, 32'(i + 1)}) begin
        errors++; $display("FAIL basic_beat%0d got %h want %h", i, b, {(i % 4) == 3, 32'(i + 1)});
      end
    end
    checks++; if (pkt_count !== 32'd2) begin errors++; $display("FAIL basic_pkt_count got %0d want 2", pkt_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL basic_overflow got %0b want 0", overflow); end
  endtask

  task automatic test_shift_sign();
    obs_beats.delete();
    drive_cycle(1, 2, 2, 1, 32'hFFFF_FFF8, 1, 0);
    drive_cycle(1, 2, 2, 1, 32'd13, 1, 0);
    for (int i = 0; i < 3; i++) drive_cycle(1, 2, 2, 0, '0, 1, 0);
    checks++; if (obs_beats.size() != 2) begin errors++; $display("FAIL shift_beats got %0d want 2", obs_beats.size()); end
    else begin
      checks++; if (obs_beats[0] !== {1'b0, 32'hFFFF_FFFE}) begin errors++; $display("FAIL shift_neg got %h want 0fffffffe", obs_beats[0]); end
      checks++; if (obs_beats[1] !== {1'b1, 32'd3}) begin errors++; $display("FAIL shift_pos got %h want 100000003", obs_beats[1]); end
    end
  endtask

  task automatic test_graceful_stop();
    obs_beats.delete();
    drive_cycle(1, 5, 0, 1, 32'd101, 1, 0);
    drive_cycle(1, 5, 0, 1, 32'd102, 1, 0);
    for (int i = 3; i <= 7; i++) drive_cycle(0, 5, 0, 1, 32'(100 + i), 1, 0);
    for (int i = 0; i < 4; i++) drive_cycle(0, 5, 0, 0, '0, 1, 0);
    checks++; if (obs_beats.size() != 5) begin errors++; $display("FAIL stop_beats got %0d want 5", obs_beats.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (obs_beats[i] !== {i == 4, 32'(101 + i)}) begin
          errors++; $display("FAIL stop_beat%0d got %h want %h", i, obs_beats[i], {i == 4, 32'(101 + i)});
        end
      end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL stop_overflow got %0b want 0", overflow); end
    drive_cycle(0, 5, 0, 1, 32'd555, 0, 0);
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL stop_idle level got %0d want 0", fifo_level); end
  endtask

  task automatic test_overflow();
    int tl;
    apply_reset();
    drive_cycle(1, 32, 0, 0, '0, 0, 0);
    for (int i = 0; i < 20; i++) drive_cycle(1, 32, 0, 1, 32'(1000 + i), 0, 0);
    checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL ovf_level got %0d want 16", fifo_level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b want 1", overflow); end
    checks++; if (m_axis.tdata !== 32'd1000) begin errors++; $display("FAIL ovf_head got %0d want 1000", m_axis.tdata); end
    for (int i = 0; i < 18; i++) drive_cycle(1, 32, 0, 0, '0, 1, 0);
    checks++; if (obs_beats.size() != 16) begin errors++; $display("FAIL ovf_drain got %0d want 16", obs_beats.size()); end
    tl = 0;
    foreach (obs_beats[i]) if (obs_beats[i][32]) tl++;
    checks++; if (tl != 0) begin errors++; $display("FAIL ovf_early_tlast got %0d want 0", tl); end
    for (int i = 0; i < 16; i++) drive_cycle(1, 32, 0, 1, 32'(2000 + i), 1, 0);
    for (int i = 0; i < 3; i++) drive_cycle(1, 32, 0, 0, '0, 1, 0);
    checks++; if (obs_beats.size() != 32) begin errors++; $display("FAIL ovf_total got %0d want 32", obs_beats.size()); end
    else begin
      checks++; if (obs_beats[31] !== {1'b1, 32'd2015}) begin errors++; $display("FAIL ovf_last got %h want 1000007df", obs_beats[31]); end
    end
    checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL ovf_pkt_count got %0d want 1", pkt_count); end
    drive_cycle(1, 32, 0, 0, '0, 1, 1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0b want 0", overflow); end
  endtask

  task automatic test_pkt_len_zero();
    int tl;
    apply_reset();
    drive_cycle(1, 0, 0, 0, '0, 1, 0);
    for (int i = 0; i < 3; i++) drive_cycle(1, 0, 0, 1, 32'(50 + i), 1, 0);
    for (int i = 0; i < 3; i++) drive_cycle(1, 0, 0, 0, '0, 1, 0);
    tl = 0;
    foreach (obs_beats[i]) if (obs_beats[i][32]) tl++;
    checks++; if (tl != 3) begin errors++; $display("FAIL len0_tlast got %0d want 3", tl); end
    checks++; if (pkt_count !== 32'd3) begin errors++; $display("FAIL len0_pkt_count got %0d want 3", pkt_count); end
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    drive_cycle(1, 4, 0, 0, '0, 0, 0);
    for (int i = 0; i < 6; i++) drive_cycle(1, 4, 0, 1, 32'(300 + i), 0, 0);
    checks++; if (fifo_level !== 5'd6) begin errors++; $display("FAIL mid_buffered got %0d want 6", fifo_level); end
    apply_reset();
    checks++; if (m_axis.tvalid !== 1'b0) begin errors++; $display("FAIL mid_tvalid got %0b want 0", m_axis.tvalid); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL mid_level got %0d want 0", fifo_level); end
    checks++; if (pkt_count !== 32'd0) begin errors++; $display("FAIL mid_pkt_count got %0d want 0", pkt_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow got %0b want 0", overflow); end
    drive_cycle(1, 3, 0, 0, '0, 1, 0);
    for (int i = 0; i < 3; i++) drive_cycle(1, 3, 0, 1, 32'(400 + i), 1, 0);
    for (int i = 0; i < 3; i++) drive_cycle(1, 3, 0, 0, '0, 1, 0);
    checks++; if (obs_beats.size() != 3) begin errors++; $display("FAIL mid_new_beats got %0d want 3", obs_beats.size()); end
    else begin
      checks++; if (obs_beats[2] !== {1'b1, 32'd402}) begin errors++; $display("FAIL mid_new_tlast got %h want 100000192", obs_beats[2]); end
      checks++; if (obs_beats[1][32] !== 1'b0) begin errors++; $display("FAIL mid_new_early_tlast got %0b want 0", obs_beats[1][32]); end
    end
  endtask

  task automatic test_random();
    bit en, vld, rdy, clr;
    int len, sh;
    logic [31:0] din;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      en  = ($urandom_range(0, 9) < 8);
      len = $urandom_range(0, 5);
      sh  = $urandom_range(0, 31);
      vld = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 19) == 0);
      din = $urandom;
      drive_cycle(en, len, sh, vld, din, rdy, clr);
      checks++;
      if (m_axis.tvalid !== (m_q.size() != 0)) begin
        errors++; $display("FAIL rand_tvalid c%0d got %0b want %0b", c, m_axis.tvalid, m_q.size() != 0);
      end
      checks++;
      if (fifo_level !== 5'(m_q.size())) begin
        errors++; $display("FAIL rand_level c%0d got %0d want %0d", c, fifo_level, m_q.size());
      end
      checks++;
      if (overflow !== m_ovf) begin
        errors++; $display("FAIL rand_overflow c%0d got %0b want %0b", c, overflow, m_ovf);
      end
      checks++;
      if (pkt_count !== m_pkts) begin
        errors++; $display("FAIL rand_pkt_count c%0d got %0d want %0d", c, pkt_count, m_pkts);
      end
      if (m_q.size() != 0) begin
        checks++;
        if ({m_axis.tlast, m_axis.tdata} !== m_q[0]) begin
          errors++; $display("FAIL rand_head c%0d got %h want %h", c, {m_axis.tlast, m_axis.tdata}, m_q[0]);
        end
      end
    end
    checks++;
    if (obs_beats.size() != exp_beats.size()) begin
      errors++; $display("FAIL rand_beat_count got %0d want %0d", obs_beats.size(), exp_beats.size());
    end else begin
      foreach (exp_beats[i]) begin
        checks++;
        if (obs_beats[i] !== exp_beats[i]) begin
          errors++; $display("FAIL rand_beat%0d got %h want %h", i, obs_beats[i], exp_beats[i]);
        end
      end
    end
  endtask

  initial begin
    m_axis.tready = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_basic_packet();
    test_shift_sign();
    test_graceful_stop();
    test_overflow();
    test_pkt_len_zero();
    test_reset_mid_packet();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_sample_packetizer.md
Name: axis_sample_packetizer

Overview:
- Downstream stage of the moving-average decimator in the sample generator.
- Consumes its valid-qualified accumulated samples, which carry no backpressure, and applies a per-packet arithmetic right-shift for scaling.
- Buffers samples in a small FIFO and emits fixed-length AXI-Stream packets with tlast.
- Drops samples on FIFO overflow and flags the drop, so upstream never stalls.

Parameters:
- DATA_WIDTH, 32, width of input samples and m_axis_tdata.
- FIFO_DEPTH_LOG2, 4, FIFO depth = 2**FIFO_DEPTH_LOG2 entries (default 16).
- PKT_LEN_WIDTH, 16, width of pkt_len and of the internal packet counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  start/stop request; acted on only at packet boundaries.
- pkt_len  in  PKT_LEN_WIDTH  samples per packet; 0 treated as 1; latched at packet start.
- shift  in  5  arithmetic right-shift applied to each sample; latched at packet start.
- in_data_valid  in  1  sample strobe from decimator; no ready returned.
- in_data  in  DATA_WIDTH  signed sample.
- m_axis_tdata  out  DATA_WIDTH  shifted sample.
- m_axis_tvalid  out  1  AXI-Stream valid.
- m_axis_tready  in  1  AXI-Stream ready.
- m_axis_tlast  out  1  last sample of packet.
- overflow  out  1  sticky; set when a sample is dropped because the FIFO is full.
- clear_overflow  in  1  clears overflow; a drop in the same cycle wins and keeps it set.
- fifo_level  out  FIFO_DEPTH_LOG2+1  current FIFO occupancy.
- pkt_count  out  32  number of packets completed on the output (tlast handshakes); wraps modulo 2**32.

Behaviour:
- Reset: state IDLE; FIFO emptied; m_axis_tvalid=0; m_axis_tlast=0; m_axis_tdata=0; overflow=0; fifo_level=0; pkt_count=0; write counter=0. Reset mid-packet discards the partial packet and all buffered data.
- States: IDLE, STREAM.
  - IDLE: in_data_valid is ignored and nothing is written. enable=1 moves to STREAM on the next cycle. Samples arriving on the transition cycle are still dropped, without setting overflow.
  - STREAM: a write is attempted on every cycle with in_data_valid=1.
  - STREAM -> IDLE only when enable=0 and the write counter is 0 (packet boundary). If enable falls mid-packet, writing continues until the packet completes, so partial packets are never emitted.
- Packet start: the write attempt with write counter=0 latches pkt_len (0 becomes 1) and shift.
- Write path:
  - Stored word = {tlast_bit, in_data >>> shift_latched}, sign-preserving.
  - shift >= DATA_WIDTH yields all sign bits.
  - tlast_bit = (write counter == pkt_len_latched-1).
  - On an accepted write, the counter increments, or wraps to 0 when tlast_bit=1.
- Full / overflow:
  - A write is accepted if fifo_level < 2**FIFO_DEPTH_LOG2, or if an output handshake occurs in the same cycle.
  - Otherwise the sample is dropped, overflow is set, and the write counter is not advanced; the packet stays whole but loses that sample.
- Output: FIFO is first-word-fall-through.
  - m_axis_tvalid = (fifo_level != 0), registered. A sample written in cycle N is presented no earlier than cycle N+1.
  - tdata and tlast come from the FIFO head and are held stable while tvalid=1 and tready=0; tvalid never drops without a handshake.
  - Handshake (tvalid & tready) pops one entry. Back-to-back handshakes sustain one sample per clock.
- Simultaneous push and pop: fifo_level is unchanged. The pointers wrap modulo the FIFO depth.
- pkt_count increments on each handshake with tlast=1.
- Throughput: with tready held high, no drops occur for any input rate up to one sample per clock.

Test Plan:
- Basic packet: rst, enable=1, pkt_len=4, shift=0, tready=1, samples 1,2,3,4,5,6,7,8 consecutive -> tdata 1..8, tlast on 4 and 8, pkt_count=2, overflow=0.
- Shift/sign: shift=2, input -8 (0xFFFFFFF8), then 13 -> outputs 0xFFFFFFFE and 3.
- Backpressure/overflow: depth 16, tready=0, pkt_len=32, 20 valid samples -> fifo_level=16, overflow=1, tdata held at first sample. Then tready=1 -> 16 samples out, no tlast yet. Next 16 written samples close the packet with tlast on the 32nd accepted sample.
- Graceful stop: pkt_len=5, enable dropped after 2nd sample, 5 more samples sent -> exactly 5 samples written with tlast on the 5th, state IDLE, 6th/7th ignored, overflow=0.
- pkt_len=0: stream 3 samples -> tlast on every beat, pkt_count=3.
- Reset mid-operation: 6 samples buffered with tready=0, assert rst one cycle -> tvalid=0, fifo_level=0, pkt_count=0, overflow=0. A subsequent packet starts with write counter 0.
